// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter sequencer and its tick generator.
package counter_seq_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam int DEF_MIN_DIV     = 2;
    localparam int DEF_LOAD_CYCLES = 4;

    // Half-period of cnt_clk in clk cycles, with small dividers clamped up.
    function automatic int halfPeriod(input int div, input int minDiv);
        return ((div < minDiv) ? minDiv : div) + 1;
    endfunction

endpackage

// File: rtl/counter_sequencer_tick_gen.sv
// Prescaler producing the cnt_clk square wave plus strobes marking the end of each low phase.
module seq_tick_gen #(
    parameter int PW = 9
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [PW-1:0] half_period,
    output logic          cnt_clk,
    output logic          rise,
    output logic          low_end
);

    logic [PW-1:0] r_pre;
    logic          r_phase;
    logic          w_wrap;

    assign w_wrap = (r_pre == half_period - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre   <= '0;
            r_phase <= 1'b0;
        end else if (clear) begin
            r_pre   <= '0;
            r_phase <= 1'b0;
        end else if (w_wrap) begin
            r_pre   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_pre   <= r_pre + 1'b1;
        end
    end

    // low_end is the decision point; rise only fires when the owner lets the wave continue.
    assign cnt_clk = r_phase;
    assign low_end = w_wrap & ~r_phase;
    assign rise    = low_end & ~clear;

endmodule

// File: rtl/counter_sequencer.sv
// Command sequencer for the external up/down counter: load, tick to the end value, report done.
// Optional readback checking of cnt_q is enabled by defining SEQ_READBACK_CHECK_EN.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIV_W       = 8,
    parameter int LOAD_CYCLES = DEF_LOAD_CYCLES,
    parameter int MIN_DIV     = DEF_MIN_DIV
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
    input  logic             cmd_up,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             cmd_repeat,
    input  logic             abort,
    output logic             cnt_enable,
    output logic             cnt_clk,
    output logic             cnt_load,
    output logic             cnt_up_down,
    output logic [WIDTH-1:0] cnt_value,
    input  logic [WIDTH-1:0] cnt_q,
    output logic [WIDTH-1:0] cur_value,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err
);

    localparam int PW = DIV_W + 1;
    localparam int LW = $clog2(LOAD_CYCLES + 1);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_start, r_end, r_shadow;
    logic [DIV_W-1:0] r_div;
    logic             r_up, r_repeat, r_aborted;
    logic [LW-1:0]    r_loadCnt;
    logic [PW-1:0]    w_half;
    logic             w_clear, w_rise, w_lowEnd, w_loadLast, w_rbErr;

    assign w_half     = PW'(halfPeriod(int'(r_div), MIN_DIV));
    assign w_loadLast = (r_state == LOAD) && (r_loadCnt == LW'(LOAD_CYCLES - 1));
    assign w_clear    = (r_state != RUN) || (w_next != RUN);

`ifdef SEQ_READBACK_CHECK_EN
    logic r_err;

    assign w_rbErr = (w_loadLast && (cnt_q != r_start)) ||
                     ((r_state == RUN) && w_lowEnd && (cnt_q != r_shadow));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_rbErr)
            r_err <= 1'b1;
    end

    assign err = r_err;
`else
    logic w_unusedQ;

    assign w_unusedQ = ^cnt_q;
    assign w_rbErr   = 1'b0;
    assign err       = 1'b0;
`endif

    seq_tick_gen #(.PW(PW)) u_tick (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_clear),
        .half_period(w_half),
        .cnt_clk    (cnt_clk),
        .rise       (w_rise),
        .low_end    (w_lowEnd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Abort and readback errors take priority over every normal exit.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (cmd_valid) w_next = LOAD;
            LOAD: begin
                if (abort)
                    w_next = IDLE;
                else if (w_loadLast)
                    w_next = w_rbErr ? IDLE : ((r_start == r_end) ? DONE : RUN);
            end
            RUN: begin
                if (abort)
                    w_next = IDLE;
                else if (w_lowEnd && w_rbErr)
                    w_next = IDLE;
                else if (w_lowEnd && (r_shadow == r_end))
                    w_next = DONE;
            end
            DONE: begin
                if (abort)
                    w_next = IDLE;
                else
                    w_next = r_repeat ? LOAD : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        cnt_enable  = 1'b0;
        cnt_load    = 1'b0;
        cnt_up_down = 1'b0;
        cnt_value   = '0;
        case (r_state)
            IDLE: cmd_ready = 1'b1;
            LOAD: begin
                busy        = 1'b1;
                cnt_enable  = 1'b1;
                cnt_load    = 1'b1;
                cnt_up_down = r_up;
                cnt_value   = r_start;
            end
            RUN: begin
                busy        = 1'b1;
                cnt_enable  = 1'b1;
                cnt_up_down = r_up;
                cnt_value   = r_start;
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                cnt_enable  = 1'b1;
                cnt_up_down = r_up;
                cnt_value   = r_start;
            end
            default: cmd_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start   <= '0;
            r_end     <= '0;
            r_div     <= '0;
            r_up      <= 1'b0;
            r_repeat  <= 1'b0;
            r_shadow  <= '0;
            r_loadCnt <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= abort && (r_state != IDLE);
            if ((r_state == IDLE) && cmd_valid) begin
                r_start  <= cmd_start;
                r_end    <= cmd_end;
                r_div    <= cmd_div;
                r_up     <= cmd_up;
                r_repeat <= cmd_repeat;
            end
            // The shadow steps on the same edge that raises cnt_clk, wrapping mod 2^WIDTH.
            if (r_state == LOAD)
                r_shadow <= r_start;
            else if ((r_state == RUN) && w_rise)
                r_shadow <= r_up ? r_shadow + 1'b1 : r_shadow - 1'b1;
            if (r_state == LOAD)
                r_loadCnt <= r_loadCnt + 1'b1;
            else
                r_loadCnt <= '0;
        end
    end

    assign aborted   = r_aborted;
    assign cur_value = r_shadow;

endmodule
